pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the single-cycle RV32 core, successor to the basic PC register. It supplies the fetch address each cycle and supports sequential, branch (PC+imm), JALR (rs1+imm) and MRET redirects. It also provides stall hold, trap entry to a fixed vector with exception-PC and cause capture, misaligned-target detection, a post-reset boot bubble and a retired-instruction counter. It sits between the decode/branch-compare logic and the instruction memory.

## Interface
Parameters:
- XLEN, 32, datapath/address width
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap entry
- IALIGN, 4, instruction alignment in bytes (2 or 4)

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  synchronous, active-low reset
- stall_i  in  1  hold PC; no retire
- pcsel_i  in  2  redirect select: SEQ=0, BRANCH=1, JALR=2, MRET=3
- rs1_i  in  XLEN  JALR base
- immext_i  in  XLEN  sign-extended immediate
- trap_i  in  1  synchronous exception from current instruction (illegal/ecall)
- pc_o  out  XLEN  current fetch PC
- pc_plus4_o  out  XLEN  pc_o + 4, link value
- pc_valid_o  out  1  pc_o holds an instruction to execute
- misalign_o  out  1  selected target is misaligned (combinational)
- epc_o  out  XLEN  captured exception PC
- cause_o  out  2  0=none, 1=misaligned target, 2=trap_i
- instret_o  out  64  retired-instruction count

## Operation
- Reset applies on the clk_i edge with rst_ni=0: pc_o=RESET_VECTOR, epc_o=0, cause_o=0, instret_o=0, state=BOOT, pc_valid_o=0.
- Target computation, modulo 2^XLEN with wrap-around and no overflow flag:
  - SEQ: pc_o+4
  - BRANCH: pc_o+immext_i
  - JALR: (rs1_i+immext_i) & ~1
  - MRET: epc_o
- Misaligned: target[1:0]!=0 when IALIGN=4; target[0]!=0 when IALIGN=2. Checked for BRANCH and JALR only. Captured epc values are always aligned, so MRET is never checked.
- FSM states: BOOT, RUN, TRAP.
  - BOOT: pc_valid_o=0, pc_o held, unconditional transition to RUN next cycle. Inputs are ignored.
  - RUN: pc_valid_o=1. Priority is trap_i > misaligned > stall_i > pcsel_i.
    - trap_i: epc_o<=pc_o, cause_o<=2, pc_o<=TRAP_VECTOR, go to TRAP, no retire. trap_i wins even while stall_i=1.
    - Misaligned target: epc_o<=pc_o, cause_o<=1, pc_o<=TRAP_VECTOR, go to TRAP, no retire.
    - stall_i: all state held, no retire.
    - Otherwise: pc_o<=target and instret_o increments by 1.
  - TRAP: pc_valid_o=0, one-cycle flush bubble, pc_o held at TRAP_VECTOR, then RUN. Inputs are ignored.
- MRET does not clear cause_o. cause_o is overwritten only by the next trap.
- instret_o wraps from 2^64-1 to 0.

## Timing
- pc_o, epc_o, cause_o, instret_o and pc_valid_o are registered.
- pc_plus4_o and misalign_o are combinational from the current pc_o and inputs.
- Redirect latency is 1 cycle: the target is visible on pc_o the cycle after pcsel_i is sampled.
- Trap entry takes 2 cycles before fetch resumes: TRAP_VECTOR appears on pc_o next cycle with pc_valid_o=0 for that cycle, and pc_valid_o=1 the cycle after.
- rst_ni low mid-operation (any state, any input) forces the reset values on that edge. Reset overrides trap_i and stall_i.

## Structure
- Package pc_pkg holds:
  - pcsel_e enum (SEQ, BRANCH, JALR, MRET)
  - pc_state_e (BOOT, RUN, TRAP)
  - cause_e (CAUSE_NONE, CAUSE_MISALIGN, CAUSE_TRAP)
- Sub-module pc_target_calc is purely combinational: target mux, adders, JALR bit-0 clear, misalign check. It is parametrised by XLEN and IALIGN.
- pc_unit holds the FSM, PC/EPC/cause registers and the instret counter.

## Test plan
- Reset and sequential fetch:
  - Stimulus: release rst_ni, pcsel=SEQ, 4 cycles.
  - Response: pc_o 0, 0 (BOOT, valid=0), 4, 8, 12; instret_o=3.
- Branch and JALR:
  - Stimulus: at pc=0x20, BRANCH with imm=0xFFFF_FFF0; then JALR with rs1=0x101, imm=0.
  - Response: pc_o=0x10, then 0x100 (bit 0 cleared); no misalign.
- Misaligned branch trap and return:
  - Stimulus: at pc=0x40, BRANCH imm=6 (IALIGN=4); later MRET.
  - Response: misalign_o=1; next pc_o=0x100, cause_o=1, epc_o=0x40, valid=0 for one cycle; after MRET, pc_o=0x40, cause_o still 1.
- Stall versus trap:
  - Stimulus: stall_i=1 for 3 cycles at pc=0x8.
  - Response: pc_o held at 0x8, instret_o unchanged.
  - Stimulus: stall_i=1 with trap_i=1.
  - Response: pc_o=0x100, cause_o=2.
- Wrap-around: SEQ at pc=0xFFFF_FFFC gives pc_o=0x0 and pc_plus4_o=0x0 at the wrapped PC's predecessor.
- Mid-operation reset: rst_ni=0 while in TRAP gives pc_o=RESET_VECTOR, cause_o=0, epc_o=0, instret_o=0, state BOOT.

Source files
------------

// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared types and helpers for the program-counter unit of the single-cycle
// RV32 core.
//   pcsel_e    : redirect select driven by decode / branch-compare logic
//   pc_state_e : sequencing state of the PC unit (boot bubble, run, trap bubble)
//   cause_e    : reason code recorded on trap entry
//   addr_misaligned() : alignment check shared by the target calculator
// -----------------------------------------------------------------------------
package pc_pkg;

    // Redirect select encodings as seen on the pcsel_i port.
    localparam logic [1:0] PCSEL_SEQ    = 2'd0;
    localparam logic [1:0] PCSEL_BRANCH = 2'd1;
    localparam logic [1:0] PCSEL_JALR   = 2'd2;
    localparam logic [1:0] PCSEL_MRET   = 2'd3;

    typedef enum logic [1:0] {
        SEQ    = PCSEL_SEQ,
        BRANCH = PCSEL_BRANCH,
        JALR   = PCSEL_JALR,
        MRET   = PCSEL_MRET
    } pcsel_e;

    // State encodings kept as plain constants so older tooling and waveform
    // decoders that expect fixed codes keep working.
    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_TRAP = 2'd2;

    typedef enum logic [1:0] {
        BOOT = ST_BOOT,
        RUN  = ST_RUN,
        TRAP = ST_TRAP
    } pc_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_MISALIGN = 2'd1,
        CAUSE_TRAP     = 2'd2
    } cause_e;

    // Returns 1 when an address with the given two low bits violates the
    // instruction alignment. half_align=1 selects 2-byte alignment (only bit 0
    // matters); otherwise 4-byte alignment is enforced.
    function automatic logic addr_misaligned(input logic [1:0] addr_lo,
                                             input logic       half_align);
        logic mis;
        if (half_align) begin
            mis = addr_lo[0];
        end else begin
            mis = (addr_lo != 2'b00);
        end
        return mis;
    endfunction

endpackage : pc_pkg

// File: rtl/pc_target_calc.sv
// -----------------------------------------------------------------------------
// pc_target_calc
// Purely combinational next-PC calculator.
// Ports:
//   pc_i        current fetch PC
//   pcsel_i     redirect select (SEQ / BRANCH / JALR / MRET)
//   rs1_i       JALR base register value
//   immext_i    sign-extended immediate
//   epc_i       captured exception PC (MRET return address)
//   target_o    selected next PC (all arithmetic wraps modulo 2^XLEN)
//   pc_plus4_o  pc_i + 4, also the link value
//   misalign_o  selected BRANCH/JALR target violates IALIGN
// -----------------------------------------------------------------------------
module pc_target_calc
    import pc_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned IALIGN = 4
) (
    input  logic [XLEN-1:0] pc_i,
    input  pcsel_e          pcsel_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] immext_i,
    input  logic [XLEN-1:0] epc_i,
    output logic [XLEN-1:0] target_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            misalign_o
);

    localparam logic HALF_ALIGN = (IALIGN == 2) ? 1'b1 : 1'b0;

    logic [XLEN-1:0] seq_tgt_s;
    logic [XLEN-1:0] branch_tgt_s;
    logic [XLEN-1:0] jalr_sum_s;
    logic [XLEN-1:0] jalr_tgt_s;

    assign seq_tgt_s    = pc_i + XLEN'(4);
    assign branch_tgt_s = pc_i + immext_i;
    assign jalr_sum_s   = rs1_i + immext_i;
    // JALR always discards bit 0 of the sum before the alignment check, so
    // only bit 1 can still trip the check under 4-byte alignment.
    assign jalr_tgt_s   = {jalr_sum_s[XLEN-1:1], 1'b0};

    assign pc_plus4_o = seq_tgt_s;

    // Target mux plus alignment check. SEQ is aligned by construction and the
    // captured EPC is always aligned, so only BRANCH and JALR are checked.
    always_comb begin
        target_o   = seq_tgt_s;
        misalign_o = 1'b0;
        case (pcsel_i)
            SEQ: begin
                target_o   = seq_tgt_s;
                misalign_o = 1'b0;
            end
            BRANCH: begin
                target_o   = branch_tgt_s;
                misalign_o = addr_misaligned(branch_tgt_s[1:0], HALF_ALIGN);
            end
            JALR: begin
                target_o   = jalr_tgt_s;
                misalign_o = addr_misaligned(jalr_tgt_s[1:0], HALF_ALIGN);
            end
            MRET: begin
                target_o   = epc_i;
                misalign_o = 1'b0;
            end
            default: begin
                target_o   = seq_tgt_s;
                misalign_o = 1'b0;
            end
        endcase
    end

endmodule : pc_target_calc

// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit
// Program-counter unit for the single-cycle RV32 core. Supplies the fetch
// address each cycle, applies sequential/branch/JALR/MRET redirects, holds on
// stall, enters a fixed trap vector on exceptions or misaligned targets, and
// counts retired instructions.
// Ports:
//   clk_i       core clock
//   rst_ni      synchronous active-low reset
//   stall_i     hold PC, no retire
//   pcsel_i     redirect select (0 SEQ, 1 BRANCH, 2 JALR, 3 MRET)
//   rs1_i       JALR base
//   immext_i    sign-extended immediate
//   trap_i      synchronous exception of the current instruction
//   pc_o        current fetch PC (registered)
//   pc_plus4_o  pc_o + 4 link value (combinational)
//   pc_valid_o  pc_o holds an instruction to execute (registered)
//   misalign_o  selected target misaligned (combinational)
//   epc_o       captured exception PC (registered)
//   cause_o     0 none, 1 misaligned target, 2 trap_i (registered)
//   instret_o   retired-instruction count, wraps at 2^64 (registered)
// Sequencing: BOOT (one bubble after reset) -> RUN; a trap or misaligned
// target goes RUN -> TRAP (one flush bubble at TRAP_VECTOR) -> RUN.
// -----------------------------------------------------------------------------
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned     IALIGN       = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            stall_i,
    input  logic [1:0]      pcsel_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] immext_i,
    input  logic            trap_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            pc_valid_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] epc_o,
    output logic [1:0]      cause_o,
    output logic [63:0]     instret_o
);

    pc_state_e       state_q,   state_d;
    logic [XLEN-1:0] pc_q,      pc_d;
    logic [XLEN-1:0] epc_q,     epc_d;
    cause_e          cause_q,   cause_d;
    logic [63:0]     instret_q, instret_d;
    logic            valid_q,   valid_d;

    logic [XLEN-1:0] target_s;
    logic            misalign_s;

    pc_target_calc #(
        .XLEN   (XLEN),
        .IALIGN (IALIGN)
    ) u_target_calc (
        .pc_i       (pc_q),
        .pcsel_i    (pcsel_e'(pcsel_i)),
        .rs1_i      (rs1_i),
        .immext_i   (immext_i),
        .epc_i      (epc_q),
        .target_o   (target_s),
        .pc_plus4_o (pc_plus4_o),
        .misalign_o (misalign_s)
    );

    // Next-state logic: sequencing FSM, redirect/trap selection and retire count.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        epc_d     = epc_q;
        cause_d   = cause_q;
        instret_d = instret_q;
        case (state_q)
            BOOT: begin
                // Boot bubble: nothing executes, inputs are ignored.
                state_d = RUN;
            end
            RUN: begin
                if (trap_i) begin
                    // An exception wins even when the pipeline asks to stall.
                    epc_d   = pc_q;
                    cause_d = CAUSE_TRAP;
                    pc_d    = TRAP_VECTOR;
                    state_d = TRAP;
                end else if (misalign_s) begin
                    epc_d   = pc_q;
                    cause_d = CAUSE_MISALIGN;
                    pc_d    = TRAP_VECTOR;
                    state_d = TRAP;
                end else if (stall_i) begin
                    state_d = RUN;
                end else begin
                    pc_d      = target_s;
                    instret_d = instret_q + 64'd1;
                    state_d   = RUN;
                end
            end
            TRAP: begin
                // Flush bubble at the trap vector; inputs are ignored.
                state_d = RUN;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
        // Validity is registered alongside the state so pc_valid_o is a flop.
        valid_d = (state_d == RUN);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= BOOT;
            pc_q      <= RESET_VECTOR;
            epc_q     <= {XLEN{1'b0}};
            cause_q   <= CAUSE_NONE;
            instret_q <= 64'd0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            epc_q     <= epc_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
            valid_q   <= valid_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_valid_o = valid_q;
    assign misalign_o = misalign_s;
    assign epc_o      = epc_q;
    assign cause_o    = cause_q;
    assign instret_o  = instret_q;

endmodule : pc_unit

// File: tb/tb_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_unit
// Self-checking bench for pc_unit (XLEN=32, RESET_VECTOR=0, TRAP_VECTOR=0x100,
// IALIGN=4). A directed table walks reset, sequential fetch, stall, branch,
// JALR, misaligned-target trap, MRET return, stall-vs-trap, PC wrap-around and
// mid-trap reset. A random phase then compares every cycle against a
// behavioural model built from the architectural rules.
// -----------------------------------------------------------------------------
module tb_pc_unit;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_ni, stall_i, trap_i;
    logic [1:0]  pcsel_i;
    logic [31:0] rs1_i, immext_i;
    logic [31:0] pc_o, pc_plus4_o, epc_o;
    logic        pc_valid_o, misalign_o;
    logic [1:0]  cause_o;
    logic [63:0] instret_o;

    always #5 clk = ~clk;

    pc_unit #(
        .XLEN         (32),
        .RESET_VECTOR (RV),
        .TRAP_VECTOR  (TV),
        .IALIGN       (4)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .stall_i    (stall_i),
        .pcsel_i    (pcsel_i),
        .rs1_i      (rs1_i),
        .immext_i   (immext_i),
        .trap_i     (trap_i),
        .pc_o       (pc_o),
        .pc_plus4_o (pc_plus4_o),
        .pc_valid_o (pc_valid_o),
        .misalign_o (misalign_o),
        .epc_o      (epc_o),
        .cause_o    (cause_o),
        .instret_o  (instret_o)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst_n, stall, trap;
        logic [1:0]  sel;
        logic [31:0] rs1, imm;
        logic        chk_comb;
        logic [31:0] p4;
        logic        mis;
        logic [31:0] pc;
        logic        valid;
        logic [1:0]  cause;
        logic [31:0] epc;
        logic [63:0] instret;
    } vec_t;

    vec_t tbl [24];

    function automatic vec_t mk(input logic rst_n, input logic stall, input logic trap,
                                input logic [1:0] sel, input logic [31:0] rs1, input logic [31:0] imm,
                                input logic chk_comb, input logic [31:0] p4, input logic mis,
                                input logic [31:0] pc, input logic valid, input logic [1:0] cause,
                                input logic [31:0] epc, input logic [63:0] instret);
        vec_t v;
        v.rst_n = rst_n; v.stall = stall; v.trap = trap; v.sel = sel; v.rs1 = rs1; v.imm = imm;
        v.chk_comb = chk_comb; v.p4 = p4; v.mis = mis; v.pc = pc; v.valid = valid;
        v.cause = cause; v.epc = epc; v.instret = instret;
        return v;
    endfunction

    // Behavioural model: architectural PC state and a phase number
    // (0 = boot bubble, 1 = executing, 2 = trap bubble).
    logic [31:0] m_pc, m_epc;
    logic [1:0]  m_cause;
    logic [63:0] m_instret;
    int          m_phase;

    function automatic void model_target(input logic [1:0] sel, input logic [31:0] rs1,
                                         input logic [31:0] imm, output logic [31:0] tgt,
                                         output logic mis);
        case (sel)
            2'd0:    tgt = m_pc + 32'd4;
            2'd1:    tgt = m_pc + imm;
            2'd2: begin
                tgt = rs1 + imm;
                tgt = tgt - (tgt % 32'd2);
            end
            default: tgt = m_epc;
        endcase
        mis = ((sel == 2'd1) || (sel == 2'd2)) && ((tgt % 32'd4) != 32'd0);
    endfunction

    function automatic void model_step(input logic rst_n, input logic stall, input logic trap,
                                       input logic [1:0] sel, input logic [31:0] rs1,
                                       input logic [31:0] imm);
        logic [31:0] tgt;
        logic        mis;
        if (!rst_n) begin
            m_pc = RV; m_epc = 32'd0; m_cause = 2'd0; m_instret = 64'd0; m_phase = 0;
        end else if (m_phase != 1) begin
            m_phase = 1;
        end else begin
            model_target(sel, rs1, imm, tgt, mis);
            if (trap) begin
                m_epc = m_pc; m_cause = 2'd2; m_pc = TV; m_phase = 2;
            end else if (mis) begin
                m_epc = m_pc; m_cause = 2'd1; m_pc = TV; m_phase = 2;
            end else if (!stall) begin
                m_pc = tgt; m_instret = m_instret + 64'd1;
            end
        end
    endfunction

    logic        r_rst, r_stall, r_trap;
    logic [1:0]  r_sel;
    logic [31:0] r_rs1, r_imm, r_tgt;
    logic        r_mis;

    initial begin
        rst_ni = 1'b0; stall_i = 1'b0; trap_i = 1'b0; pcsel_i = 2'd0;
        rs1_i = 32'd0; immext_i = 32'd0;

        //          rst   stl   trp   sel   rs1            imm            cc    p4             mis   pc             vld   cse   epc            instret
        tbl[0]  = mk(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,         32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 2'd0, 32'h0,         64'd0);
        tbl[1]  = mk(1'b1, 1'b0, 1'b1, 2'd0, 32'h0,         32'h0,         1'b1, 32'h4,         1'b0, 32'h0,         1'b1, 2'd0, 32'h0,         64'd0);
        tbl[2]  = mk(1'b1, 1'b0, 1'b0, 2'd0, 32'h0,         32'h0,         1'b1, 32'h4,         1'b0, 32'h4,         1'b1, 2'd0, 32'h0,         64'd1);
        tbl[3]  = mk(1'b1, 1'b0, 1'b0, 2'd0, 32'h0,         32'h0,         1'b1, 32'h8,         1'b0, 32'h8,         1'b1, 2'd0, 32'h0,         64'd2);
        tbl[4]  = mk(1'b1, 1'b1, 1'b0, 2'd0, 32'h0,         32'h0,         1'b1, 32'hC,         1'b0, 32'h8,         1'b1, 2'd0, 32'h0,         64'd2);
        tbl[5]  = mk(1'b1, 1'b1, 1'b0, 2'd0, 32'h0,         32'h0,         1'b1, 32'hC,         1'b0, 32'h8,         1'b1, 2'd0, 32'h0,         64'd2);
        tbl[6]  = mk(1'b1, 1'b1, 1'b0, 2'd0, 32'h0,         32'h0,         1'b1, 32'hC,         1'b0, 32'h8,         1'b1, 2'd0, 32'h0,         64'd2);
        tbl[7]  = mk(1'b1, 1'b0, 1'b0, 2'd0, 32'h0,         32'h0,         1'b1, 32'hC,         1'b0, 32'hC,         1'b1, 2'd0, 32'h0,         64'd3);
        tbl[8]  = mk(1'b1, 1'b0, 1'b0, 2'd1, 32'h0,         32'h14,        1'b1, 32'h10,        1'b0, 32'h20,        1'b1, 2'd0, 32'h0,         64'd4);
        tbl[9]  = mk(1'b1, 1'b0, 1'b0, 2'd1, 32'h0,         32'hFFFF_FFF0, 1'b1, 32'h24,        1'b0, 32'h10,        1'b1, 2'd0, 32'h0,         64'd5);
        tbl[10] = mk(1'b1, 1'b0, 1'b0, 2'd2, 32'h101,       32'h0,         1'b1, 32'h14,        1'b0, 32'h100,       1'b1, 2'd0, 32'h0,         64'd6);
        tbl[11] = mk(1'b1, 1'b0, 1'b0, 2'd1, 32'h0,         32'hFFFF_FF40, 1'b1, 32'h104,       1'b0, 32'h40,        1'b1, 2'd0, 32'h0,         64'd7);
        tbl[12] = mk(1'b1, 1'b0, 1'b0, 2'd1, 32'h0,         32'h6,         1'b1, 32'h44,        1'b1, 32'h100,       1'b0, 2'd1, 32'h40,        64'd7);
        tbl[13] = mk(1'b1, 1'b1, 1'b1, 2'd0, 32'h0,         32'h0,         1'b1, 32'h104,       1'b0, 32'h100,       1'b1, 2'd1, 32'h40,        64'd7);
        tbl[14] = mk(1'b1, 1'b0, 1'b0, 2'd3, 32'h0,         32'h0,         1'b1, 32'h104,       1'b0, 32'h40,        1'b1, 2'd1, 32'h40,        64'd8);
        tbl[15] = mk(1'b1, 1'b1, 1'b1, 2'd0, 32'h0,         32'h0,         1'b1, 32'h44,        1'b0, 32'h100,       1'b0, 2'd2, 32'h40,        64'd8);
        tbl[16] = mk(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,         32'h0,         1'b1, 32'h104,       1'b0, 32'h0,         1'b0, 2'd0, 32'h0,         64'd0);
        tbl[17] = mk(1'b1, 1'b0, 1'b1, 2'd0, 32'h0,         32'h0,         1'b1, 32'h4,         1'b0, 32'h0,         1'b1, 2'd0, 32'h0,         64'd0);
        tbl[18] = mk(1'b1, 1'b0, 1'b0, 2'd1, 32'h0,         32'hFFFF_FFFC, 1'b1, 32'h4,         1'b0, 32'hFFFF_FFFC, 1'b1, 2'd0, 32'h0,         64'd1);
        tbl[19] = mk(1'b1, 1'b0, 1'b0, 2'd0, 32'h0,         32'h0,         1'b1, 32'h0,         1'b0, 32'h0,         1'b1, 2'd0, 32'h0,         64'd2);
        tbl[20] = mk(1'b1, 1'b0, 1'b0, 2'd2, 32'h103,       32'h0,         1'b1, 32'h4,         1'b1, 32'h100,       1'b0, 2'd1, 32'h0,         64'd2);
        tbl[21] = mk(1'b1, 1'b0, 1'b0, 2'd0, 32'h0,         32'h0,         1'b1, 32'h104,       1'b0, 32'h100,       1'b1, 2'd1, 32'h0,         64'd2);
        tbl[22] = mk(1'b1, 1'b1, 1'b0, 2'd1, 32'h0,         32'h2,         1'b1, 32'h104,       1'b1, 32'h100,       1'b0, 2'd1, 32'h100,       64'd2);
        tbl[23] = mk(1'b1, 1'b0, 1'b0, 2'd0, 32'h0,         32'h0,         1'b1, 32'h104,       1'b0, 32'h100,       1'b1, 2'd1, 32'h100,       64'd2);

        @(posedge clk);
        #1;

        // Directed table: inputs applied after an edge, combinational outputs
        // checked mid-cycle, registered outputs checked just after the next edge.
        for (int i = 0; i < 24; i++) begin
            rst_ni = tbl[i].rst_n; stall_i = tbl[i].stall; trap_i = tbl[i].trap;
            pcsel_i = tbl[i].sel; rs1_i = tbl[i].rs1; immext_i = tbl[i].imm;
            #2;
            if (tbl[i].chk_comb) begin
                chk($sformatf("tbl%0d_pc_plus4", i), pc_plus4_o, tbl[i].p4);
                chk($sformatf("tbl%0d_misalign", i), misalign_o, tbl[i].mis);
            end
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_pc", i),      pc_o,       tbl[i].pc);
            chk($sformatf("tbl%0d_valid", i),   pc_valid_o, tbl[i].valid);
            chk($sformatf("tbl%0d_cause", i),   cause_o,    tbl[i].cause);
            chk($sformatf("tbl%0d_epc", i),     epc_o,      tbl[i].epc);
            chk($sformatf("tbl%0d_instret", i), instret_o,  tbl[i].instret);
        end

        // Random phase against the behavioural model; the first cycle is a
        // reset so the model starts in a known state.
        for (int i = 0; i < 3000; i++) begin
            r_rst   = (i == 0) ? 1'b0 : ($urandom_range(0, 149) != 0);
            r_stall = ($urandom_range(0, 4) == 0);
            r_trap  = ($urandom_range(0, 19) == 0);
            r_sel   = 2'($urandom_range(0, 3));
            r_rs1   = $urandom();
            r_imm   = $urandom();
            if ($urandom_range(0, 3) != 0) begin
                r_imm[1:0] = 2'b00;
                r_rs1[1]   = 1'b0;
            end
            rst_ni = r_rst; stall_i = r_stall; trap_i = r_trap;
            pcsel_i = r_sel; rs1_i = r_rs1; immext_i = r_imm;
            #2;
            if (i > 0) begin
                model_target(r_sel, r_rs1, r_imm, r_tgt, r_mis);
                chk("rnd_pc_plus4", pc_plus4_o, m_pc + 32'd4);
                chk("rnd_misalign", misalign_o, r_mis);
            end
            model_step(r_rst, r_stall, r_trap, r_sel, r_rs1, r_imm);
            @(posedge clk);
            #1;
            chk("rnd_pc",      pc_o,       m_pc);
            chk("rnd_valid",   pc_valid_o, (m_phase == 1));
            chk("rnd_cause",   cause_o,    m_cause);
            chk("rnd_epc",     epc_o,      m_epc);
            chk("rnd_instret", instret_o,  m_instret);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_pc_unit
